// File: rtl/alu_out_pipe_if.sv
// Handshake bundle between the ALU result pipe and its neighbours.
// ALU_OUT_PIPE_ZERO_FLAG_EN adds the out_zero signal.
interface alu_out_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] occupancy;
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
  logic             out_zero;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy, out_zero
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy, out_zero
  );
`else
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
`endif
endinterface

// File: rtl/alu_out_pipe.sv
// Elastic DEPTH-stage ALU result pipe with bubble collapsing, flush and occupancy.
// Optional ALU_OUT_PIPE_ZERO_FLAG_EN carries an in_data==0 flag alongside each entry.
module alu_out_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  alu_out_pipe_if.slave bus
);
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] prev_valid;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data_reg  [DEPTH];
  logic [WIDTH-1:0] prev_data [DEPTH];
  logic [CNT_W-1:0] occ_reg;
  logic [CNT_W-1:0] occ_next;
  logic             in_xfer;
  logic             out_xfer;
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
  logic [DEPTH-1:0] zero_reg;
  logic [DEPTH-1:0] prev_zero;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // A stage moves unless it and every stage ahead of it is full while downstream stalls.
      assign adv[gi] = bus.out_ready | ~(&valid_reg[DEPTH-1:gi]);
      if (gi == 0) begin : g_head
        assign prev_valid[gi] = bus.in_valid;
        assign prev_data[gi]  = bus.in_data;
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
        assign prev_zero[gi]  = (bus.in_data == '0);
`endif
      end else begin : g_body
        assign prev_valid[gi] = valid_reg[gi-1];
        assign prev_data[gi]  = data_reg[gi-1];
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
        assign prev_zero[gi]  = zero_reg[gi-1];
`endif
      end
      assign valid_next[gi] = ~bus.flush & (adv[gi] ? prev_valid[gi] : valid_reg[gi]);
    end
  endgenerate

  assign in_xfer  = bus.in_valid & adv[0];
  assign out_xfer = valid_reg[DEPTH-1] & bus.out_ready;

  always_comb begin
    occ_next = occ_reg;
    if (bus.flush)
      occ_next = '0;
    else if (in_xfer && !out_xfer)
      occ_next = occ_reg + CNT_W'(1);
    else if (out_xfer && !in_xfer)
      occ_next = occ_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      occ_reg   <= '0;
      for (int k = 0; k < DEPTH; k++)
        data_reg[k] <= '0;
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
      zero_reg  <= '0;
`endif
    end else begin
      valid_reg <= valid_next;
      occ_reg   <= occ_next;
      // Payload only moves on advance; flush clears validity, not data.
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          data_reg[k] <= prev_data[k];
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
          zero_reg[k] <= prev_zero[k];
`endif
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_reg[DEPTH-1];
  assign bus.out_data  = valid_reg[DEPTH-1] ? data_reg[DEPTH-1] : '0;
  assign bus.occupancy = occ_reg;
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
  assign bus.out_zero  = zero_reg[DEPTH-1] & valid_reg[DEPTH-1];
`endif
endmodule

// File: tb/tb_alu_out_pipe.sv
// Randomised and directed bench for alu_out_pipe against a queue-of-entries model.
// Entries are tracked by stage position; ALU_OUT_PIPE_ZERO_FLAG_EN also checks out_zero.
module tb_alu_out_pipe;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_out_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_out_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } ent_t;

  ent_t mq[$];
  ent_t nq[$];
  logic [WIDTH-1:0] got[$];
  int n_checks = 0;
  int n_pass = 0;
  int lim;
  int np;
  bit m_ir;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_out_valid();
    return (mq.size() > 0) && (mq[0].pos == DEPTH-1);
  endfunction

  // Model: every entry steps one stage closer to the output unless the slot ahead stays occupied.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      m_ir = bus.out_ready || (mq.size() < DEPTH);
      nq.delete();
      lim = bus.out_ready ? DEPTH + 1 : DEPTH;
      for (int i = 0; i < mq.size(); i++) begin
        np = (mq[i].pos + 1 < lim - 1) ? mq[i].pos + 1 : lim - 1;
        lim = np;
        if (np < DEPTH) nq.push_back('{d: mq[i].d, pos: np});
      end
      if (bus.in_valid && m_ir) nq.push_back('{d: bus.in_data, pos: 0});
      if (bus.flush) nq.delete();
      mq = nq;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(bus.out_valid), 64'(m_out_valid()));
    chk("out_data", 64'(bus.out_data), m_out_valid() ? 64'(mq[0].d) : 64'd0);
    chk("occupancy", 64'(bus.occupancy), 64'(mq.size()));
    chk("in_ready", 64'(bus.in_ready), 64'(!reset && (bus.out_ready || mq.size() < DEPTH) || reset));
`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
    chk("out_zero", 64'(bus.out_zero), 64'(m_out_valid() && (mq[0].d == '0)));
`endif
    if (!reset && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency: accepted at the first edge, visible after the second.
    drive(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("lat_early", 64'(bus.out_valid), 64'd0);
    cyc();
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_data", 64'(bus.out_data), 64'h0000_00A5);
    cyc();

    // Asynchronous reset mid-cycle with an entry held at the output.
    drive(1'b1, 32'hBB, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    chk("pre_areset_valid", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 64'(bus.out_valid), 64'd0);
    chk("areset_data", 64'(bus.out_data), 64'd0);
    chk("areset_occ", 64'(bus.occupancy), 64'd0);
    cyc();
    reset = 1'b0;
    chk("areset_in_ready", 64'(bus.in_ready), 64'd1);

    // Streaming 1..8.
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
      if (i >= 3) chk("stream_occ", 64'(bus.occupancy), 64'd2);
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      cyc();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("stream_cnt", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("stream_val", 64'(got[i]), 64'(i + 1));

    // Backpressure until full.
    got.delete();
    drive(1'b1, 32'h11, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h22, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_occ", 64'(bus.occupancy), 64'd2);
    chk("full_head", 64'(bus.out_data), 64'h11);
    cyc();
    chk("full_hold", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cyc();
    chk("bp_cnt", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_0", 64'(got[0]), 64'h11);
      chk("bp_1", 64'(got[1]), 64'h22);
      chk("bp_2", 64'(got[2]), 64'h33);
    end

    // Bubble collapse under stall.
    got.delete();
    drive(1'b1, 32'h44, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h55, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, 1'b0, 1'b0); cyc();
    chk("bubble_occ", 64'(bus.occupancy), 64'd2);
    chk("bubble_head", 64'(bus.out_data), 64'h44);
    drive(1'b0, '0, 1'b1, 1'b0); cyc();
    chk("bubble_next", 64'(bus.out_data), 64'h55);
    repeat (2) cyc();
    chk("bubble_cnt", 64'(got.size()), 64'd2);

    // Flush with a simultaneous input.
    got.delete();
    drive(1'b1, 32'h77, 1'b0, 1'b0); cyc();
    drive(1'b1, 32'h78, 1'b0, 1'b0); cyc();
    chk("preflush_occ", 64'(bus.occupancy), 64'd2);
    drive(1'b1, 32'h66, 1'b0, 1'b1); cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_occ", 64'(bus.occupancy), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_data", 64'(bus.out_data), 64'd0);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    chk("flush_nothing_out", 64'(got.size()), 64'd0);

`ifdef ALU_OUT_PIPE_ZERO_FLAG_EN
    drive(1'b1, 32'h0, 1'b1, 1'b0); cyc();
    drive(1'b1, 32'h7, 1'b1, 1'b0); cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("zf_data0", 64'(bus.out_data), 64'd0);
    chk("zf_flag0", 64'(bus.out_zero), 64'd1);
    cyc();
    chk("zf_data7", 64'(bus.out_data), 64'd7);
    chk("zf_flag7", 64'(bus.out_zero), 64'd0);
    cyc();
    chk("zf_idle", 64'(bus.out_zero), 64'd0);
`endif

    // Random traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 31) == 0));
      cyc();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cyc();
    chk("drained_occ", 64'(bus.occupancy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
